mem_arbiter: RTL and testbench

- Memory controller between the out-of-order core and the byte-wide unified RAM port.
- Arbitrates two requesters: instruction fetch (32-bit word reads) and the load/store buffer (byte/half/word loads and stores).
- Sequences each multi-byte access as consecutive single-byte RAM cycles, assembling read words little-endian.
- Returns completion tagged with the LSB slot position.

---
 rtl/mem_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: memory controller between the core and a byte-wide unified RAM.
//
// Arbitrates instruction fetch (32-bit word reads) against the load/store
// buffer (1/2/4-byte loads and stores) with round-robin fairness, then runs
// each access as consecutive single-byte RAM cycles. Read words are assembled
// little-endian; RAM read data arrives one cycle after its address.
//
// state  | meaning
// IDLE   | no access in flight; grants are evaluated here
// IF_RD  | fetching a 4-byte instruction word
// LD_RD  | reading 1/2/4 bytes for an LSB load
// ST_WR  | writing 1/2/4 bytes for an LSB store
//
// Ports:
//   clk_in, rst_in (async, active high), rdy_in (freeze when low), clear (flush)
//   if_req/if_addr           -> if_done/if_data          fetch side
//   lsb_req/pos/ls/len/addr/val -> mem_busy, mem_finished/mem_val/mem_pos
//   ram_din, ram_dout, ram_a, ram_wr                     byte RAM port
module mem_arbiter #(
  parameter int LSB_CAP_BIT = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   clear,
  input  logic                   if_req,
  input  logic [31:0]            if_addr,
  output logic                   if_done,
  output logic [31:0]            if_data,
  input  logic                   lsb_req,
  input  logic [LSB_CAP_BIT-1:0] lsb_pos,
  input  logic                   lsb_ls,
  input  logic [1:0]             lsb_len,
  input  logic [31:0]            lsb_addr,
  input  logic [31:0]            lsb_val,
  output logic                   mem_busy,
  output logic                   mem_finished,
  output logic [31:0]            mem_val,
  output logic [LSB_CAP_BIT-1:0] mem_pos,
  input  logic [7:0]             ram_din,
  output logic [7:0]             ram_dout,
  output logic [31:0]            ram_a,
  output logic                   ram_wr
);

  typedef enum logic [1:0] {IDLE, IF_RD, LD_RD, ST_WR} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             k_q, k_d;
  logic [2:0]             n_q, n_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            val_q, val_d;
  logic [LSB_CAP_BIT-1:0] pos_q, pos_d;
  logic [31:0]            buf_q, buf_d;
  logic                   last_grant_q, last_grant_d;
  logic                   orphan_q, orphan_d;
  logic                   if_done_q, if_done_d;
  logic [31:0]            if_data_q, if_data_d;
  logic                   mem_finished_q, mem_finished_d;
  logic [31:0]            mem_val_q, mem_val_d;
  logic [LSB_CAP_BIT-1:0] mem_pos_q, mem_pos_d;
  logic [7:0]             ram_dout_q, ram_dout_d;
  logic [31:0]            ram_a_q, ram_a_d;
  logic                   ram_wr_q, ram_wr_d;

  logic [2:0] k_inc;
  logic [1:0] rd_sel;
  logic [2:0] lsb_n;

  assign k_inc  = k_q + 3'd1;
  // Byte arriving now was addressed one cycle ago, i.e. index k-1.
  assign rd_sel = 2'(k_q - 3'd1);

  always_comb begin
    unique case (lsb_len)
      2'b00:   lsb_n = 3'd1;
      2'b01:   lsb_n = 3'd2;
      default: lsb_n = 3'd4;
    endcase
  end

  // IF holding while the last grant went to the LSB makes the LSB wait,
  // which is what gives the fetch side its round-robin turn.
  assign mem_busy = (state_q != IDLE) || (if_req && last_grant_q) || clear || !rdy_in;

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    n_d            = n_q;
    addr_d         = addr_q;
    val_d          = val_q;
    pos_d          = pos_q;
    buf_d          = buf_q;
    last_grant_d   = last_grant_q;
    orphan_d       = orphan_q;
    if_done_d      = 1'b0;
    if_data_d      = if_data_q;
    mem_finished_d = 1'b0;
    mem_val_d      = mem_val_q;
    mem_pos_d      = mem_pos_q;
    ram_dout_d     = ram_dout_q;
    ram_a_d        = ram_a_q;
    ram_wr_d       = ram_wr_q;

    if (rdy_in) begin
      unique case (state_q)
        IDLE: begin
          if (!clear) begin
            if (lsb_req && !mem_busy) begin
              last_grant_d = 1'b1;
              addr_d       = lsb_addr;
              val_d        = lsb_val;
              pos_d        = lsb_pos;
              n_d          = lsb_n;
              k_d          = 3'd0;
              buf_d        = '0;
              orphan_d     = 1'b0;
              ram_a_d      = lsb_addr;
              if (lsb_ls) begin
                state_d    = ST_WR;
                ram_wr_d   = 1'b1;
                ram_dout_d = lsb_val[7:0];
              end else begin
                state_d    = LD_RD;
              end
            end else if (if_req) begin
              last_grant_d = 1'b0;
              addr_d       = if_addr;
              n_d          = 3'd4;
              k_d          = 3'd0;
              buf_d        = '0;
              ram_a_d      = if_addr;
              state_d      = IF_RD;
            end
          end
        end

        IF_RD, LD_RD: begin
          if (clear) begin
            state_d = IDLE;
            k_d     = 3'd0;
          end else begin
            if (k_q != 3'd0) buf_d[{rd_sel, 3'b000} +: 8] = ram_din;
            if (k_q == n_q) begin
              state_d = IDLE;
              k_d     = 3'd0;
              if (state_q == IF_RD) begin
                if_done_d = 1'b1;
                if_data_d = buf_d;
              end else begin
                mem_finished_d = 1'b1;
                mem_val_d      = buf_d;
                mem_pos_d      = pos_q;
              end
            end else begin
              k_d = k_inc;
              if (k_inc < n_q) ram_a_d = addr_q + {29'd0, k_inc};
            end
          end
        end

        ST_WR: begin
          // A store already issued is architecturally committed: finish all
          // bytes, but a flush means nobody is waiting for the completion.
          if (clear) orphan_d = 1'b1;
          if (k_q == n_q - 3'd1) begin
            state_d  = IDLE;
            k_d      = 3'd0;
            ram_wr_d = 1'b0;
            orphan_d = 1'b0;
            if (!(orphan_q || clear)) begin
              mem_finished_d = 1'b1;
              mem_pos_d      = pos_q;
            end
          end else begin
            k_d        = k_inc;
            ram_a_d    = addr_q + {29'd0, k_inc};
            ram_dout_d = val_q[{k_inc[1:0], 3'b000} +: 8];
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= IDLE;
      k_q            <= '0;
      n_q            <= '0;
      addr_q         <= '0;
      val_q          <= '0;
      pos_q          <= '0;
      buf_q          <= '0;
      last_grant_q   <= 1'b1;
      orphan_q       <= 1'b0;
      if_done_q      <= 1'b0;
      if_data_q      <= '0;
      mem_finished_q <= 1'b0;
      mem_val_q      <= '0;
      mem_pos_q      <= '0;
      ram_dout_q     <= '0;
      ram_a_q        <= '0;
      ram_wr_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      n_q            <= n_d;
      addr_q         <= addr_d;
      val_q          <= val_d;
      pos_q          <= pos_d;
      buf_q          <= buf_d;
      last_grant_q   <= last_grant_d;
      orphan_q       <= orphan_d;
      if_done_q      <= if_done_d;
      if_data_q      <= if_data_d;
      mem_finished_q <= mem_finished_d;
      mem_val_q      <= mem_val_d;
      mem_pos_q      <= mem_pos_d;
      ram_dout_q     <= ram_dout_d;
      ram_a_q        <= ram_a_d;
      ram_wr_q       <= ram_wr_d;
    end
  end

  assign if_done      = if_done_q;
  assign if_data      = if_data_q;
  assign mem_finished = mem_finished_q;
  assign mem_val      = mem_val_q;
  assign mem_pos      = mem_pos_q;
  assign ram_dout     = ram_dout_q;
  assign ram_a        = ram_a_q;
  // A frozen write byte must not be written repeatedly.
  assign ram_wr       = ram_wr_q && rdy_in;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear;
  logic        if_req, lsb_req, lsb_ls;
  logic [31:0] if_addr, lsb_addr, lsb_val;
  logic [1:0]  lsb_len;
  logic [3:0]  lsb_pos;
  logic [7:0]  ram_din;
  logic        if_done, mem_busy, mem_finished, ram_wr;
  logic [31:0] if_data, mem_val, ram_a;
  logic [3:0]  mem_pos;
  logic [7:0]  ram_dout;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.LSB_CAP_BIT(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .lsb_req(lsb_req), .lsb_pos(lsb_pos), .lsb_ls(lsb_ls), .lsb_len(lsb_len),
    .lsb_addr(lsb_addr), .lsb_val(lsb_val), .mem_busy(mem_busy),
    .mem_finished(mem_finished), .mem_val(mem_val), .mem_pos(mem_pos),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
  );

  always #5 clk_in = ~clk_in;

  // Environment RAM (64 KiB, aliased): unwritten bytes follow a fixed pattern.
  bit       wflag [65536];
  bit [7:0] wdata [65536];
  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return (a[7:0] * 8'd29) ^ a[15:8] ^ 8'h6B;
  endfunction
  always @(posedge clk_in) begin
    ram_din <= wflag[ram_a[15:0]] ? wdata[ram_a[15:0]] : init_byte(ram_a[15:0]);
    if (ram_wr === 1'b1) begin
      wflag[ram_a[15:0]] <= 1'b1;
      wdata[ram_a[15:0]] <= ram_dout;
    end
  end

  // Reference model: the memory as the core should see it.
  bit       sh_v [65536];
  bit [7:0] sh_d [65536];
  function automatic int n_of(input logic [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction
  function automatic logic [7:0] mdl_rd(input logic [15:0] a);
    return sh_v[a] ? sh_d[a] : init_byte(a);
  endfunction
  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] len);
    logic [31:0] v = '0;
    for (int i = 0; i < n_of(len); i++) v[8*i +: 8] = mdl_rd(16'(a + 32'(i)));
    return v;
  endfunction
  task automatic mdl_wr(input logic [31:0] a, input logic [1:0] len, input logic [31:0] v);
    for (int i = 0; i < n_of(len); i++) begin
      sh_v[16'(a + 32'(i))] = 1'b1;
      sh_d[16'(a + 32'(i))] = v[8*i +: 8];
    end
  endtask

  task automatic idle_inputs();
    if_req = 0; lsb_req = 0; clear = 0; rdy_in = 1;
  endtask

  task automatic do_reset();
    @(negedge clk_in); rst_in = 1; idle_inputs();
    @(negedge clk_in); rst_in = 0;
  endtask

  // Issues one LSB access from the current negedge and observes `budget` cycles.
  task automatic run_lsb(input logic ls, input logic [1:0] len, input logic [31:0] a, v,
                         input logic [3:0] p, input int budget,
                         output int done_c, output logic [31:0] got_v, output logic [3:0] got_p);
    lsb_req = 1; lsb_ls = ls; lsb_len = len; lsb_addr = a; lsb_val = v; lsb_pos = p;
    done_c = -1; got_v = '0; got_p = '0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk_in); lsb_req = 0;
      if (mem_finished === 1'b1 && done_c < 0) begin done_c = c; got_v = mem_val; got_p = mem_pos; end
    end
  endtask

  task automatic run_if(input logic [31:0] a, input int budget, output int done_c, output logic [31:0] got);
    if_addr = a; if_req = 1; done_c = -1; got = '0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk_in);
      if (if_done === 1'b1 && done_c < 0) begin done_c = c; got = if_data; if_req = 0; end
    end
    if_req = 0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({if_done, if_data, mem_finished, mem_val, mem_pos, ram_dout, ram_a, ram_wr} !== '0) begin
      errors++; $display("FAIL reset_outputs got ram_a=%h if_data=%h mem_val=%h", ram_a, if_data, mem_val);
    end
    checks++;
    if (mem_busy !== 1'b0) begin errors++; $display("FAIL reset_busy_idle got %b exp 0", mem_busy); end
    if_req = 1; #1;
    checks++;
    if (mem_busy !== 1'b1) begin errors++; $display("FAIL reset_last_grant busy got %b exp 1", mem_busy); end
    if_req = 0;
    @(negedge clk_in); rst_in = 0;
  endtask

  task automatic test_store_sh();
    lsb_req = 1; lsb_ls = 1; lsb_len = 2'b01; lsb_addr = 32'h200; lsb_val = 32'hABCD1234; lsb_pos = 4'd9;
    #1;
    checks++;
    if (mem_busy !== 1'b0) begin errors++; $display("FAIL sh_accept busy got %b exp 0", mem_busy); end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_in); lsb_req = 0;
      checks++;
      if (ram_wr !== (c <= 2)) begin errors++; $display("FAIL sh_wr cycle %0d got %b", c, ram_wr); end
      if (c <= 2) begin
        checks++;
        if (ram_a !== 32'h200 + 32'(c - 1) || ram_dout !== ((c == 1) ? 8'h34 : 8'h12)) begin
          errors++; $display("FAIL sh_byte cycle %0d got a=%h d=%h", c, ram_a, ram_dout);
        end
      end
      checks++;
      if (mem_finished !== (c == 3)) begin errors++; $display("FAIL sh_finished cycle %0d got %b", c, mem_finished); end
      if (c == 3) begin
        checks++;
        if (mem_pos !== 4'd9) begin errors++; $display("FAIL sh_pos got %0d exp 9", mem_pos); end
      end
    end
    mdl_wr(32'h200, 2'b01, 32'hABCD1234);
  endtask

  task automatic test_load_lw();
    int dc; logic [31:0] gv; logic [3:0] gp;
    run_lsb(1'b1, 2'b10, 32'h100, 32'h44332211, 4'd1, 8, dc, gv, gp);
    mdl_wr(32'h100, 2'b10, 32'h44332211);
    lsb_req = 1; lsb_ls = 0; lsb_len = 2'b10; lsb_addr = 32'h100; lsb_pos = 4'd5;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_in); lsb_req = 0;
      if (c <= 4) begin
        checks++;
        if (ram_a !== 32'h100 + 32'(c - 1) || ram_wr !== 1'b0) begin
          errors++; $display("FAIL lw_addr cycle %0d got a=%h wr=%b", c, ram_a, ram_wr);
        end
      end
      checks++;
      if (mem_finished !== (c == 6)) begin errors++; $display("FAIL lw_finished cycle %0d got %b", c, mem_finished); end
      if (c == 6) begin
        checks++;
        if (mem_val !== 32'h44332211 || mem_pos !== 4'd5) begin
          errors++; $display("FAIL lw_data got %h/%0d exp 44332211/5", mem_val, mem_pos);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    bit exp_if, found, lg_m;
    int n_if = 0, n_lsb = 0;
    logic [31:0] ia;
    logic [3:0] p;
    do_reset();
    lg_m = 1'b1;
    ia = 32'h1000 + 32'($urandom_range(0, 16'h6000));
    if_addr = ia; if_req = 1;
    lsb_ls = 0; lsb_len = 2'($urandom); lsb_addr = 32'h1000 + 32'($urandom_range(0, 16'h6000));
    p = 4'($urandom); lsb_pos = p; lsb_req = 1;
    #1;
    checks++;
    if (mem_busy !== 1'b1) begin errors++; $display("FAIL rr_busy_first got %b exp 1", mem_busy); end
    for (int tx = 0; tx < 10; tx++) begin
      found = 0;
      for (int c = 0; c < 20 && !found; c++) begin
        @(negedge clk_in);
        if (if_done === 1'b1 || mem_finished === 1'b1) found = 1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL rr_timeout tx %0d got none exp completion", tx); break; end
      exp_if = lg_m;
      checks++;
      if (if_done !== exp_if || mem_finished !== !exp_if) begin
        errors++; $display("FAIL rr_order tx %0d got if=%b lsb=%b exp if=%b", tx, if_done, mem_finished, exp_if);
      end
      checks++;
      if (exp_if) begin
        n_if++;
        if (if_data !== exp_load(ia, 2'b10)) begin
          errors++; $display("FAIL rr_if_data tx %0d got %h exp %h", tx, if_data, exp_load(ia, 2'b10));
        end
        ia = 32'h1000 + 32'($urandom_range(0, 16'h6000)); if_addr = ia;
      end else begin
        n_lsb++;
        if (mem_val !== exp_load(lsb_addr, lsb_len) || mem_pos !== p) begin
          errors++; $display("FAIL rr_lsb_data tx %0d got %h/%0d exp %h/%0d", tx, mem_val, mem_pos, exp_load(lsb_addr, lsb_len), p);
        end
        lsb_len = 2'($urandom); lsb_addr = 32'h1000 + 32'($urandom_range(0, 16'h6000));
        p = 4'($urandom); lsb_pos = p;
      end
      lg_m = !exp_if;
    end
    if_req = 0; lsb_req = 0;
    checks++;
    if (n_if !== 5 || n_lsb !== 5) begin errors++; $display("FAIL rr_fairness got if=%0d lsb=%0d exp 5/5", n_if, n_lsb); end
    repeat (10) @(negedge clk_in);
  endtask

  task automatic test_clear_load();
    int fin_seen = 0, if_c = -1;
    logic [31:0] d = '0, ia;
    ia = 32'h2000 + 32'($urandom_range(0, 16'h1000));
    lsb_req = 1; lsb_ls = 0; lsb_len = 2'b10; lsb_addr = 32'h3000 + 32'($urandom_range(0, 16'h1000));
    @(negedge clk_in); lsb_req = 0;
    @(negedge clk_in); clear = 1;
    @(negedge clk_in); clear = 0; #1;
    checks++;
    if (mem_busy !== 1'b0 || mem_finished !== 1'b0) begin
      errors++; $display("FAIL clr_ld_idle cycle 3 got busy=%b fin=%b exp 0/0", mem_busy, mem_finished);
    end
    if_addr = ia; if_req = 1;
    for (int c = 4; c <= 14; c++) begin
      @(negedge clk_in);
      if (c == 4) begin
        checks++;
        if (ram_a !== ia) begin errors++; $display("FAIL clr_ld_if_grant got a=%h exp %h", ram_a, ia); end
      end
      if (mem_finished === 1'b1) fin_seen++;
      if (if_done === 1'b1 && if_c < 0) begin if_c = c; d = if_data; if_req = 0; end
    end
    checks++;
    if (fin_seen !== 0) begin errors++; $display("FAIL clr_ld_no_finish got %0d pulses exp 0", fin_seen); end
    checks++;
    if (if_c !== 9 || d !== exp_load(ia, 2'b10)) begin
      errors++; $display("FAIL clr_ld_if_done got cycle %0d data %h exp 9 %h", if_c, d, exp_load(ia, 2'b10));
    end
  endtask

  task automatic test_clear_store();
    int fin_seen = 0;
    int dc; logic [31:0] gv, a, v; logic [3:0] gp;
    a = 32'h5000 + 32'($urandom_range(0, 16'h0F00)); v = $urandom;
    lsb_req = 1; lsb_ls = 1; lsb_len = 2'b10; lsb_addr = a; lsb_val = v; lsb_pos = 4'd3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_in); lsb_req = 0; clear = (c == 2); #1;
      checks++;
      if (c <= 4) begin
        if (ram_wr !== 1'b1 || ram_a !== a + 32'(c - 1) || ram_dout !== v[8*(c-1) +: 8]) begin
          errors++; $display("FAIL clr_st_byte cycle %0d got wr=%b a=%h d=%h", c, ram_wr, ram_a, ram_dout);
        end
      end else if (ram_wr !== 1'b0) begin
        errors++; $display("FAIL clr_st_wr_low cycle %0d got %b exp 0", c, ram_wr);
      end
      if (c == 5) begin
        checks++;
        if (mem_busy !== 1'b0) begin errors++; $display("FAIL clr_st_idle got busy %b exp 0", mem_busy); end
      end
      if (mem_finished === 1'b1) fin_seen++;
    end
    clear = 0;
    checks++;
    if (fin_seen !== 0) begin errors++; $display("FAIL clr_st_no_finish got %0d pulses exp 0", fin_seen); end
    mdl_wr(a, 2'b10, v);
    run_lsb(1'b0, 2'b10, a, 32'h0, 4'd2, 8, dc, gv, gp);
    checks++;
    if (dc !== 6 || gv !== v) begin errors++; $display("FAIL clr_st_readback got cycle %0d %h exp 6 %h", dc, gv, v); end
  endtask

  task automatic test_rdy_stall();
    logic [3:0] p;
    p = 4'($urandom);
    lsb_req = 1; lsb_ls = 0; lsb_len = 2'b00; lsb_addr = 32'h30000; lsb_pos = p;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk_in); lsb_req = 0; rdy_in = (c < 2 || c > 4); #1;
      if (c <= 5) begin
        checks++;
        if (ram_a !== 32'h30000) begin errors++; $display("FAIL stall_addr cycle %0d got %h exp 30000", c, ram_a); end
      end
      checks++;
      if (ram_wr !== 1'b0) begin errors++; $display("FAIL stall_wr cycle %0d got %b exp 0", c, ram_wr); end
      checks++;
      if (mem_finished !== (c == 6)) begin errors++; $display("FAIL stall_finish cycle %0d got %b", c, mem_finished); end
      if (c == 3) begin
        checks++;
        if (mem_busy !== 1'b1) begin errors++; $display("FAIL stall_busy got %b exp 1", mem_busy); end
      end
      if (c == 6) begin
        checks++;
        if (mem_val !== {24'h0, mdl_rd(16'h0000)} || mem_pos !== p) begin
          errors++; $display("FAIL stall_data got %h/%0d exp %h/%0d", mem_val, mem_pos, {24'h0, mdl_rd(16'h0000)}, p);
        end
      end
    end
    rdy_in = 1;
  endtask

  task automatic test_async_reset();
    int seen = 0;
    lsb_req = 1; lsb_ls = 0; lsb_len = 2'b10; lsb_addr = 32'h4400;
    @(negedge clk_in); lsb_req = 0;
    @(negedge clk_in); #1; rst_in = 1; #1;
    checks++;
    if ({if_done, if_data, mem_finished, mem_val, mem_pos, ram_dout, ram_a, ram_wr} !== '0) begin
      errors++; $display("FAIL areset_outputs got ram_a=%h mem_val=%h", ram_a, mem_val);
    end
    @(negedge clk_in); rst_in = 0; #1;
    checks++;
    if (mem_busy !== 1'b0) begin errors++; $display("FAIL areset_idle got busy %b exp 0", mem_busy); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_in);
      if (mem_finished === 1'b1 || if_done === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL areset_no_completion got %0d exp 0", seen); end
  endtask

  task automatic test_random();
    int dc, kind; logic [31:0] a, v, gv, ev; logic [1:0] len; logic [3:0] p, gp;
    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 2);
      a = 32'($urandom_range(0, 16'hFFFF)) | 32'h0001_0000;
      len = 2'($urandom); v = $urandom; p = 4'($urandom);
      if (kind == 0) begin
        ev = exp_load(a, 2'b10);
        run_if(a, 10, dc, gv);
        checks++;
        if (dc !== 6 || gv !== ev) begin errors++; $display("FAIL rand_if t%0d got cycle %0d %h exp 6 %h", t, dc, gv, ev); end
      end else if (kind == 1) begin
        ev = exp_load(a, len);
        run_lsb(1'b0, len, a, v, p, 8, dc, gv, gp);
        checks++;
        if (dc !== n_of(len) + 2 || gv !== ev || gp !== p) begin
          errors++; $display("FAIL rand_ld t%0d got cycle %0d %h/%0d exp %0d %h/%0d", t, dc, gv, gp, n_of(len) + 2, ev, p);
        end
      end else begin
        run_lsb(1'b1, len, a, v, p, 8, dc, gv, gp);
        mdl_wr(a, len, v);
        checks++;
        if (dc !== n_of(len) + 1 || gp !== p) begin
          errors++; $display("FAIL rand_st t%0d got cycle %0d pos %0d exp %0d pos %0d", t, dc, gp, n_of(len) + 1, p);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1; idle_inputs();
    if_addr = '0; lsb_addr = '0; lsb_val = '0; lsb_len = '0; lsb_pos = '0; lsb_ls = 0;
    test_reset();
    test_store_sh();
    test_load_lw();
    test_round_robin();
    test_clear_load();
    test_clear_store();
    test_rdy_stall();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
